mul_unit_radix: RTL and testbench
=================================

Name: mul_unit_radix

Overview:
Parametrised iterative integer multiplier for the RV64 execute stage. It replaces the fixed single-bit-per-cycle multiplier with a configurable radix and a valid/ready handshake on both sides. It also adds a destination-tag passthrough and a pipeline flush. All five M-extension multiply ops are supported: MUL, MULH, MULHSU, MULHU, MULW.

Parameters:
XLEN, 64, operand/result width; must be 64 (MULW semantics fixed to 32-bit word).
BITS_PER_CYCLE, 2, multiplier bits retired per iteration; one of 1,2,4,8.
TAG_WIDTH, 6, width of destination tag (physical register index).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept request this cycle
inst_op_f3  in  10  {opcode[6:0], funct3}
mult_op1  in  XLEN  rs1 value
mult_op2  in  XLEN  rs2 value
in_tag  in  TAG_WIDTH  destination tag
flush  in  1  kill in-flight op
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
product_val  out  XLEN  result
out_tag  out  TAG_WIDTH  tag of result
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0, product_val=0, out_tag=0, busy_o=0, in_ready=1 once rst deasserts.
- Op decode:
  - 0110011_000 MUL: low XLEN bits, signed×signed.
  - 0110011_001 MULH: high XLEN bits, signed×signed.
  - 0110011_010 MULHSU: high XLEN bits, signed op1 × unsigned op2.
  - 0110011_011 MULHU: high XLEN bits, unsigned×unsigned.
  - 0111011_000 MULW: op1[31:0]×op2[31:0]; low 32 bits of product, sign-extended to XLEN.
  - Any other code is accepted, produces product_val=0, and uses normal 64-bit latency.
- Algorithm:
  - At accept, latch the magnitudes of both operands (per signedness of op), the result sign = sign1 XOR sign2 (signed operands only), the op and the tag.
  - Shift-add, BITS_PER_CYCLE bits of |op2| per iteration, into a 2×XLEN accumulator.
  - Final two's-complement negate if the sign is set, folded into the last iteration's registered output.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on in_valid && in_ready; iteration counter N = 64/BITS_PER_CYCLE (32/BITS_PER_CYCLE for MULW).
  - BUSY: counter decrements each cycle; at count 1 -> DONE with product_val, out_tag and out_valid=1 registered.
  - DONE: holds product_val and out_tag stable until out_ready. On out_ready -> IDLE, or -> BUSY if a new request is accepted the same cycle.
- Latency: out_valid rises N+1 cycles after the accept edge (R=2: 33 for 64-bit ops, 17 for MULW).
- in_ready = (state==IDLE) || (state==DONE && out_ready); combinational, no dependence on in_valid.
- flush:
  - Any state -> IDLE next edge; out_valid drops; the pending result is discarded.
  - flush with in_valid in the same cycle: no accept (in_ready is forced 0 while flush=1).
- rst mid-operation: immediate abort, outputs take reset values.
- Inputs are sampled only at accept; changes to mult_op1, mult_op2 or inst_op_f3 during BUSY have no effect.

Optional Feature:
MUL_EARLY_OUT_EN
- Defined: when the remaining unprocessed bits of the latched |op2| are all zero after an iteration, the unit goes directly to DONE with the correctly shifted and sign-corrected result. At least 1 iteration is always performed.
- Undefined: fixed latency N+1 always.
- Results are bit-identical in both builds.

Test Plan:
1. MUL 5 × −5 (op2=0xFFFFFFFFFFFFFFFB), R=2 -> product_val=0xFFFFFFFFFFFFFFE7, out_valid exactly 33 cycles after accept, out_tag=in_tag. With MUL_EARLY_OUT_EN: 3 cycles.
2. MULH 5 × −5 -> 0xFFFFFFFFFFFFFFFF. MULHSU 5 × 0xFFFFFFFFFFFFFFFB -> 0x0000000000000004. MULHU 0xFFFFFFFFFFFFFFFB × 0xFFFFFFFFFFFFFFFB -> 0xFFFFFFFFFFFFFFF6.
3. MULW −5 × −5 -> 0x0000000000000019 after 17 cycles. MULW 0x7FFFFFFF × 2 -> 0xFFFFFFFFFFFFFFFE.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> product_val and out_tag stable, in_ready=0. Then assert out_ready with in_valid=1 -> result retired and next op accepted in the same cycle; busy_o stays 1.
5. flush asserted 5 cycles into BUSY -> out_valid never rises for that op, IDLE next cycle. A new request (3 × 7) accepted afterwards -> 0x15 with correct latency. flush with in_valid in IDLE -> no accept.
6. Async rst pulse mid-BUSY (between clock edges) -> out_valid, busy_o and product_val go 0 without a clock edge. Repeat tests 1-3 for BITS_PER_CYCLE = 1, 4 and 8 with latency 64/R+1.

Source files
------------

// File: rtl/mul_unit_radix.sv
// mul_unit_radix: iterative RV64 integer multiplier (MUL, MULH, MULHSU, MULHU, MULW).
//
// The magnitudes of both operands are latched at accept. Each BUSY cycle adds
// BITS_PER_CYCLE partial products of |op2| into a 2*XLEN accumulator. The sign
// correction and result selection are folded into the registered output of the
// last iteration.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload until that edge. The unit
// holds out_valid, product_val and out_tag stable until out_ready. in_ready is a
// function of state, out_ready and flush only; it never depends on in_valid.
//
// Optional build macro: MUL_EARLY_OUT_EN. When it is defined, the unit leaves
// BUSY as soon as the remaining bits of |op2| are all zero. At least one
// iteration is always done. Results are identical in both builds.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid/in_ready            request handshake
//   inst_op_f3                   {opcode[6:0], funct3}
//   mult_op1, mult_op2, in_tag   request payload (rs1, rs2, destination tag)
//   flush                        kill the in-flight op; blocks accept this cycle
//   out_valid/out_ready          result handshake
//   product_val, out_tag         result payload
//   busy_o                       state != IDLE
//   state_o                      FSM state, for debug (0 IDLE, 1 BUSY, 2 DONE)
module mul_unit_radix #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_WIDTH      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9:0]           inst_op_f3,
  input  logic [XLEN-1:0]      mult_op1,
  input  logic [XLEN-1:0]      mult_op2,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      product_val,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW, OP_BAD} op_t;

  localparam int          CNT_W = 7;
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN / BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32 / BITS_PER_CYCLE);

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic                  neg_q, neg_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]       product_q, product_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

  // Request decode and operand magnitudes, combinational from the inputs.
  op_t             op_dec;
  logic            s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0] a_raw, b_raw, mag1, mag2;

  always_comb begin
    op_dec = OP_BAD;
    case (inst_op_f3)
      10'b0110011_000: op_dec = OP_MUL;
      10'b0110011_001: op_dec = OP_MULH;
      10'b0110011_010: op_dec = OP_MULHSU;
      10'b0110011_011: op_dec = OP_MULHU;
      10'b0111011_000: op_dec = OP_MULW;
      default:         op_dec = OP_BAD;
    endcase
    s1_signed = (op_dec == OP_MUL) || (op_dec == OP_MULH) || (op_dec == OP_MULHSU);
    s2_signed = (op_dec == OP_MUL) || (op_dec == OP_MULH);
    // The low 32 bits of a word product do not depend on signedness, so MULW
    // multiplies the zero-extended words.
    if (op_dec == OP_MULW) begin
      a_raw = {32'b0, mult_op1[31:0]};
      b_raw = {32'b0, mult_op2[31:0]};
    end else begin
      a_raw = mult_op1;
      b_raw = mult_op2;
    end
    neg1 = s1_signed && a_raw[XLEN-1];
    neg2 = s2_signed && b_raw[XLEN-1];
    mag1 = neg1 ? (~a_raw + 1'b1) : a_raw;
    mag2 = neg2 ? (~b_raw + 1'b1) : b_raw;
  end

  // One iteration: add the partial products for the low BITS_PER_CYCLE bits of |op2|.
  logic [2*XLEN-1:0] partial, acc_step, res_signed;
  logic [XLEN-1:0]   mplier_next, final_val;
  logic              last_iter;

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
    acc_step    = acc_q + partial;
    mplier_next = mplier_q >> BITS_PER_CYCLE;
`ifdef MUL_EARLY_OUT_EN
    // The multiplicand shifts with the multiplier, so acc_step is already the
    // complete product once no set bits remain.
    last_iter = (cnt_q == CNT_W'(1)) || (mplier_next == '0);
`else
    last_iter = (cnt_q == CNT_W'(1));
`endif
    res_signed = neg_q ? (~acc_step + 1'b1) : acc_step;
    case (op_q)
      OP_MUL:                         final_val = res_signed[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   final_val = res_signed[2*XLEN-1:XLEN];
      OP_MULW:                        final_val = {{(XLEN-32){res_signed[31]}}, res_signed[31:0]};
      default:                        final_val = '0;
    endcase
  end

  assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  logic accept;
  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    tag_d     = tag_q;
    product_d = product_q;
    out_tag_d = out_tag_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_BUSY: begin
          cnt_d    = cnt_q - CNT_W'(1);
          acc_d    = acc_step;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_next;
          if (last_iter) begin
            state_d   = S_DONE;
            product_d = final_val;
            out_tag_d = tag_q;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      // Accept is possible from IDLE, and from DONE while the result retires.
      if (accept) begin
        state_d  = S_BUSY;
        op_d     = op_dec;
        cnt_d    = (op_dec == OP_MULW) ? N_WORD : N_FULL;
        mcand_d  = {{XLEN{1'b0}}, mag1};
        mplier_d = mag2;
        acc_d    = '0;
        neg_d    = neg1 ^ neg2;
        tag_d    = in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_BAD;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      tag_q     <= '0;
      product_q <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      tag_q     <= tag_d;
      product_q <= product_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign out_valid   = (state_q == S_DONE);
  assign product_val = product_q;
  assign out_tag     = out_tag_q;
  assign busy_o      = (state_q != S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_mul_unit_radix.sv
module tb_mul_unit_radix;
  parameter int BPC = 2;
  localparam int N64 = 64 / BPC;
  localparam int N32 = 32 / BPC;

  localparam logic [9:0] F_MUL    = 10'b0110011_000;
  localparam logic [9:0] F_MULH   = 10'b0110011_001;
  localparam logic [9:0] F_MULHSU = 10'b0110011_010;
  localparam logic [9:0] F_MULHU  = 10'b0110011_011;
  localparam logic [9:0] F_MULW   = 10'b0111011_000;
  localparam logic [9:0] F_DIV    = 10'b0110011_100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  inst_op_f3 = '0;
  logic [63:0] mult_op1 = '0;
  logic [63:0] mult_op2 = '0;
  logic [5:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product_val;
  logic [5:0]  out_tag;
  logic        busy_o;
  logic [1:0]  state_o;

  mul_unit_radix #(.XLEN(64), .BITS_PER_CYCLE(BPC), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_op_f3(inst_op_f3), .mult_op1(mult_op1), .mult_op2(mult_op2), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .product_val(product_val), .out_tag(out_tag),
    .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Cycles from the accept cycle to out_valid: iterations + 1.
  function automatic int exp_lat(input logic [63:0] mag, input int n);
`ifdef MUL_EARLY_OUT_EN
    for (int i = 1; i < n; i++) if ((mag >> (i * BPC)) == 64'd0) return i + 1;
`endif
    return n + 1 + 0 * int'(mag[0]);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [9:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] tag, input logic [63:0] exp);
    in_valid = 1'b1; inst_op_f3 = f3; mult_op1 = a; mult_op2 = b; in_tag = tag;
    #1;
    check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    // Payload changes after accept must not matter.
    inst_op_f3 = 10'($urandom); mult_op1 = {$urandom, $urandom}; mult_op2 = {$urandom, $urandom};
    in_tag = 6'($urandom);
  endtask

  task automatic wait_result(input string name, input logic [5:0] tag, input int lat);
    int cycles = 1;
    logic [63:0] exp;
    while (!out_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_lat"}, 64'(cycles), 64'(lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check(name, product_val, exp);
    check({name, "_tag"}, {58'd0, out_tag}, {58'd0, tag});
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_retire", {62'd0, state_o}, {62'd0, ST_IDLE});
  endtask

  typedef struct {
    string       name;
    logic [9:0]  f3;
    logic [63:0] a, b, exp, mag;
    logic        is_w;
  } vec_t;

  vec_t vecs[9];
  logic [63:0] held_val;
  logic        saw_valid;

  initial begin
    vecs[0] = '{"mul_5_m5",    F_MUL,    64'd5, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFE7, 64'd5, 1'b0};
    vecs[1] = '{"mulh_5_m5",   F_MULH,   64'd5, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFF, 64'd5, 1'b0};
    vecs[2] = '{"mulhsu_5",    F_MULHSU, 64'd5, 64'hFFFFFFFFFFFFFFFB, 64'h0000000000000004, 64'hFFFFFFFFFFFFFFFB, 1'b0};
    vecs[3] = '{"mulhu_fb",    F_MULHU,  64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFF6, 64'hFFFFFFFFFFFFFFFB, 1'b0};
    vecs[4] = '{"mulw_m5_m5",  F_MULW,   64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFB, 64'h19, 64'hFFFFFFFB, 1'b1};
    vecs[5] = '{"mulw_ovf",    F_MULW,   64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 64'd2, 1'b1};
    vecs[6] = '{"mulhu_ones",  F_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[7] = '{"mul_m1_m1",   F_MUL,    64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1, 1'b0};
    vecs[8] = '{"bad_op",      F_DIV,    64'd12, 64'd3, 64'd0, 64'd3, 1'b0};

    #22 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy_o}, 64'd0);
    check("rst_product",   product_val, 64'd0);
    check("rst_tag",       {58'd0, out_tag}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_state",     {62'd0, state_o}, {62'd0, ST_IDLE});

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, 6'(i + 1), vecs[i].exp);
      check({vecs[i].name, "_busy"}, {63'd0, busy_o}, 64'd1);
      check({vecs[i].name, "_in_ready_busy"}, {63'd0, in_ready}, 64'd0);
      wait_result(vecs[i].name, 6'(i + 1), exp_lat(vecs[i].mag, vecs[i].is_w ? N32 : N64));
      retire();
    end

    // MULH of the most negative value squared: 2^126.
    issue(F_MULH, 64'h8000000000000000, 64'h8000000000000000, 6'd20, 64'h4000000000000000);
    wait_result("mulh_min_min", 6'd20, exp_lat(64'h8000000000000000, N64));

    // Backpressure: hold the result for 10 cycles.
    held_val = 64'h4000000000000000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_product", product_val, held_val);
      check("bp_tag", {58'd0, out_tag}, 64'd20);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    // Retire and accept in the same cycle.
    out_ready = 1'b1;
    issue(F_MUL, 64'd3, 64'd7, 6'd21, 64'h15);
    check("b2b_busy", {63'd0, busy_o}, 64'd1);
    check("b2b_state", {62'd0, state_o}, {62'd0, ST_BUSY});
    wait_result("b2b_mul_3_7", 6'd21, exp_lat(64'd7, N64));
    retire();

    // Flush 5 cycles into BUSY.
    issue(F_MUL, 64'd9, 64'hFFFF, 6'd30, 64'd0);
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_state", {62'd0, state_o}, {62'd0, ST_IDLE});
    check("flush_busy", {63'd0, busy_o}, 64'd0);
    saw_valid = 1'b0;
    repeat (N64 + 4) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    check("flush_no_valid", {63'd0, saw_valid}, 64'd0);
    issue(F_MUL, 64'd3, 64'd7, 6'd31, 64'h15);
    wait_result("post_flush_mul", 6'd31, exp_lat(64'd7, N64));
    retire();

    // Flush together with in_valid in IDLE: no accept.
    in_valid = 1'b1; inst_op_f3 = F_MUL; mult_op1 = 64'd2; mult_op2 = 64'd2; flush = 1'b1;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_no_accept", {63'd0, busy_o}, 64'd0);

    // Async reset mid-BUSY, between clock edges.
    issue(F_MUL, 64'd11, 64'hFFFFFFFF, 6'd40, 64'd0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    check("pre_rst_product", product_val, 64'h15);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_product", product_val, 64'd0);
    check("arst_tag", {58'd0, out_tag}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_state", {62'd0, state_o}, {62'd0, ST_IDLE});

    // Unit still works after reset.
    issue(F_MULW, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFB, 6'd41, 64'h19);
    wait_result("post_rst_mulw", 6'd41, exp_lat(64'hFFFFFFFB, N32));
    retire();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
